// File: rtl/sensor_pkg.sv
// Shared types and constants for the vehicle sensor conditioning front end.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    ACTIVE   = 2'd2,
    QUAL_OFF = 2'd3
  } chan_state_e;

  // Sensor pins pull low when a vehicle is over the loop.
  localparam logic SENSOR_ACTIVE_LEVEL = 1'b0;

  // 10 ms of stability at a 50 MHz clock.
  localparam int DEBOUNCE_50MHZ = 500000;

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchronizer, qualify-on/qualify-off debounce FSM,
// registered present level and arrival pulse.
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_n,
  output logic present,
  output logic present_next,
  output logic arrive_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] TERM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] ONE  = DW'(1);

  logic          sync1, sync2, s;
  chan_state_e   state, state_next;
  logic [DW-1:0] dcnt, dcnt_next, dcnt_inc;
  logic          pulse_next;

  // Synchronizer resets to the inactive level so reset release is silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= sensor_n;
      sync2 <= sync1;
    end
  end

  assign s        = (sync2 == SENSOR_ACTIVE_LEVEL);
  assign dcnt_inc = (&dcnt) ? dcnt : dcnt + ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_next = QUAL_ON;
          dcnt_next  = ONE;
        end
      end
      QUAL_ON: begin
        if (!s) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (dcnt == TERM) begin
          state_next = ACTIVE;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_inc;
        end
      end
      ACTIVE: begin
        if (!s) begin
          state_next = QUAL_OFF;
          dcnt_next  = ONE;
        end
      end
      QUAL_OFF: begin
        if (s) begin
          state_next = ACTIVE;
          dcnt_next  = '0;
        end else if (dcnt == TERM) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        dcnt_next  = '0;
      end
    endcase
  end

  // present holds through QUAL_OFF so short dropouts never clear it.
  // A pulse fires only on the first ACTIVE cycle after QUAL_ON, which is
  // the only way to reach ACTIVE while present is still low.
  assign present_next = (state == ACTIVE) || (state == QUAL_OFF);
  assign pulse_next   = (state == ACTIVE) && !present;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      present      <= 1'b0;
      arrive_pulse <= 1'b0;
    end else begin
      present      <= present_next;
      arrive_pulse <= pulse_next;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Vehicle sensor front end: per-channel debounce plus combined presence and a
// saturating arrival counter for the HEX display.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int N_SENSORS       = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SENSORS-1:0]   sensor_n,
  input  logic                   clear_count,
  output logic [N_SENSORS-1:0]   present,
  output logic                   any_present,
  output logic [N_SENSORS-1:0]   arrive_pulse,
  output logic [COUNT_WIDTH-1:0] arrival_count
);

  localparam int CW2 = COUNT_WIDTH + 2;
  localparam logic [CW2-1:0] SAT = {2'b00, {COUNT_WIDTH{1'b1}}};

  logic [N_SENSORS-1:0]   present_next;
  logic [CW2-1:0]         pop, sum;
  logic [COUNT_WIDTH-1:0] count_next;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .sensor_n    (sensor_n[g]),
      .present     (present[g]),
      .present_next(present_next[g]),
      .arrive_pulse(arrive_pulse[g])
    );
  end

  // Two spare bits so simultaneous arrivals cannot wrap before the clamp.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SENSORS; i++) pop = pop + CW2'(arrive_pulse[i]);
    sum        = {2'b00, arrival_count} + pop;
    count_next = (sum > SAT) ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arrival_count <= '0;
      any_present   <= 1'b0;
    end else begin
      arrival_count <= clear_count ? '0 : count_next;
      any_present   <= |present_next;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with a short debounce window.
module tb_sensor_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sensor_n;
  logic       clear_count;
  logic [1:0] present;
  logic       any_present;
  logic [1:0] arrive_pulse;
  logic [3:0] arrival_count;

  sensor_conditioner #(
    .N_SENSORS(2),
    .DEBOUNCE_CYCLES(D),
    .COUNT_WIDTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_n     (sensor_n),
    .clear_count  (clear_count),
    .present      (present),
    .any_present  (any_present),
    .arrive_pulse (arrive_pulse),
    .arrival_count(arrival_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mask;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mcnt  = 0;
  logic pend  = 1'b0;
  logic [3:0] pend_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_add(input int c, input logic [1:0] m);
    int r;
    r = c + int'(m[0]) + int'(m[1]);
    return (r > 15) ? 15 : r;
  endfunction

  // Expect an arrival with the given mask; clr models a clear landing on the pulse.
  task automatic expect_arrival(input logic [1:0] m, input logic clr);
    exp_t e;
    mcnt   = clr ? 0 : sat_add(mcnt, m);
    e.mask = m;
    e.cnt  = 4'(mcnt);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (pend) begin
      chk("count_after_pulse", 32'(arrival_count), 32'(pend_cnt));
      pend = 1'b0;
    end
    if (!reset && arrive_pulse != 2'b00) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'(arrive_pulse), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_mask", 32'(arrive_pulse), 32'(e.mask));
        pend     = 1'b1;
        pend_cnt = e.cnt;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    sensor_n    = 2'b11;
    clear_count = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_present", 32'(present), 32'd0);
    chk("rst_any", 32'(any_present), 32'd0);
    chk("rst_pulse", 32'(arrive_pulse), 32'd0);
    chk("rst_count", 32'(arrival_count), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Clean arrival on channel 0.
    sensor_n[0] = 1'b0;
    expect_arrival(2'b01, 1'b0);
    repeat (6) @(negedge clk);
    chk("clean_pre_present", 32'(present[0]), 32'd0);
    @(negedge clk);
    chk("clean_present", 32'(present[0]), 32'd1);
    chk("clean_any", 32'(any_present), 32'd1);
    chk("clean_pulse", 32'(arrive_pulse[0]), 32'd1);
    @(negedge clk);
    chk("clean_pulse_end", 32'(arrive_pulse[0]), 32'd0);
    chk("clean_count", 32'(arrival_count), 32'd1);
    repeat (4) @(negedge clk);

    // Dropout glitch while active.
    sensor_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    sensor_n[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("glitch_present", 32'(present[0]), 32'd1);
    end
    sensor_n[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("depart_pre_present", 32'(present[0]), 32'd1);
    @(negedge clk);
    chk("depart_present", 32'(present[0]), 32'd0);
    chk("depart_any", 32'(any_present), 32'd0);
    repeat (4) @(negedge clk);

    // Bounce rejection on channel 1.
    for (int r = 0; r < 5; r++) begin
      sensor_n[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("bounce_present", 32'(present[1]), 32'd0);
      end
      sensor_n[1] = 1'b1;
      @(negedge clk);
      chk("bounce_present", 32'(present[1]), 32'd0);
    end
    repeat (3) @(negedge clk);
    chk("bounce_present_late", 32'(present[1]), 32'd0);
    chk("bounce_count", 32'(arrival_count), 32'(mcnt));
    sensor_n[1] = 1'b0;
    expect_arrival(2'b10, 1'b0);
    repeat (6) @(negedge clk);
    sensor_n[1] = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_depart", 32'(present[1]), 32'd0);

    // Simultaneous arrivals up to and past saturation.
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    mcnt = 0;
    @(negedge clk);
    chk("clear_count", 32'(arrival_count), 32'd0);
    for (int a = 0; a < 9; a++) begin
      sensor_n = 2'b00;
      expect_arrival(2'b11, 1'b0);
      repeat (10) @(negedge clk);
      chk("sim_present", 32'(present), 32'd3);
      sensor_n = 2'b11;
      repeat (10) @(negedge clk);
      chk("sim_depart", 32'(present), 32'd0);
    end
    chk("sat_count", 32'(arrival_count), 32'd15);

    // Clear coincident with a double arrival pulse.
    sensor_n = 2'b00;
    expect_arrival(2'b11, 1'b1);
    repeat (7) @(negedge clk);
    chk("clr_pulse", 32'(arrive_pulse), 32'd3);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    chk("clr_priority", 32'(arrival_count), 32'd0);
    sensor_n = 2'b11;
    repeat (10) @(negedge clk);

    // Reset during qualification.
    sensor_n = 2'b10;
    expect_arrival(2'b01, 1'b0);
    repeat (10) @(negedge clk);
    chk("pre_rst_present", 32'(present), 32'd1);
    chk("pre_rst_count", 32'(arrival_count), 32'd1);
    sensor_n[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_present", 32'(present), 32'd0);
    chk("async_rst_any", 32'(any_present), 32'd0);
    chk("async_rst_pulse", 32'(arrive_pulse), 32'd0);
    chk("async_rst_count", 32'(arrival_count), 32'd0);
    @(negedge clk);
    sensor_n = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mcnt  = 0;
    repeat (15) @(negedge clk);
    chk("post_rst_present", 32'(present), 32'd0);
    chk("post_rst_count", 32'(arrival_count), 32'd0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
